// File: rtl/arith_enc_sequencer_pkg.sv
// Shared definitions for the arithmetic-encoder front-end sequencer.
//   - seq_state_e        : sequencer FSM state encoding
//   - PIPE_DEPTH_DEFAULT : encoder register stages after the issue register
package arith_enc_sequencer_pkg;

    localparam int unsigned PIPE_DEPTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD      = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_FRAME_END = 2'd3
    } seq_state_e;

endpackage

// File: rtl/arith_enc_sequencer_enc_valid_chain.sv
// Valid/last shift register that shadows the encoder pipeline, plus the
// output-pending flag for the encoder final registers.
// Ports:
//   general_clk, reset : clock, synchronous active-high reset
//   pipe_en            : shared pipeline advance enable
//   issue_vld          : value loaded into vld[0] (1 = real issue, 0 = bubble)
//   issue_last         : last-of-frame flag travelling with the issue
//   out_ready          : downstream accepts the final-register result
//   vld                : vld[0..PIPE_DEPTH-1] (vld[0] = issue register)
//   out_pending        : a real result sits in the final registers
//   out_last           : that result belongs to the frame's last issue
module arith_enc_sequencer_enc_valid_chain
    import arith_enc_sequencer_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEFAULT
) (
    input  logic                  general_clk,
    input  logic                  reset,
    input  logic                  pipe_en,
    input  logic                  issue_vld,
    input  logic                  issue_last,
    input  logic                  out_ready,
    output logic [PIPE_DEPTH-1:0] vld,
    output logic                  out_pending,
    output logic                  out_last
);

    logic [PIPE_DEPTH-1:0] vld_r;
    logic [PIPE_DEPTH-1:0] last_r;
    logic                  pending_r;
    logic                  out_last_r;

    // Shift valid/last flags on every advance; the final stage is the pending flag.
    always_ff @(posedge general_clk) begin
        if (reset) begin
            vld_r      <= {PIPE_DEPTH{1'b0}};
            last_r     <= {PIPE_DEPTH{1'b0}};
            pending_r  <= 1'b0;
            out_last_r <= 1'b0;
        end else begin
            if (pipe_en) begin
                vld_r  <= {vld_r[PIPE_DEPTH-2:0], issue_vld};
                last_r <= {last_r[PIPE_DEPTH-2:0], issue_last};
            end else begin
                vld_r  <= vld_r;
                last_r <= last_r;
            end
            // A new arrival wins over a same-cycle consume.
            if (pipe_en && vld_r[PIPE_DEPTH-1]) begin
                pending_r  <= 1'b1;
                out_last_r <= last_r[PIPE_DEPTH-1];
            end else if (pending_r && out_ready) begin
                pending_r  <= 1'b0;
                out_last_r <= out_last_r;
            end else begin
                pending_r  <= pending_r;
                out_last_r <= out_last_r;
            end
        end
    end

    assign vld         = vld_r;
    assign out_pending = pending_r;
    assign out_last    = out_last_r;

endmodule

// File: rtl/arith_enc_sequencer.sv
// Front-end sequencer for the two-bool arithmetic encoder. Accepts one symbol
// per handshake, pairs consecutive booleans sharing the same probability into
// one two-bool issue, drives the encoder stage-1 registers, generates the
// shared pipeline advance enable and drains/re-initialises at end of frame.
// Ports:
//   general_clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready             : symbol handshake
//   in_bool, in_fl, in_fh,
//   in_symbol, in_nsyms, in_last  : incoming symbol (bool bit = in_symbol[0])
//   enc_*                         : registered issue to encoder stage 1
//   pipe_en                       : advance enable for all encoder registers
//   enc_reset                     : encoder state re-initialisation
//   out_valid/out_ready, out_last : result present in encoder final registers
//   busy                          : sequencer or pipeline still holds work
module arith_enc_sequencer
    import arith_enc_sequencer_pkg::*;
#(
    parameter int unsigned RANGE_WIDTH  = 16,
    parameter int unsigned SYMBOL_WIDTH = 4,
    parameter int unsigned PIPE_DEPTH   = PIPE_DEPTH_DEFAULT
) (
    input  logic                    general_clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_bool,
    input  logic [RANGE_WIDTH-1:0]  in_fl,
    input  logic [RANGE_WIDTH-1:0]  in_fh,
    input  logic [SYMBOL_WIDTH-1:0] in_symbol,
    input  logic [SYMBOL_WIDTH:0]   in_nsyms,
    input  logic                    in_last,
    output logic [RANGE_WIDTH-1:0]  enc_fl,
    output logic [RANGE_WIDTH-1:0]  enc_fh,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_1,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_2,
    output logic [SYMBOL_WIDTH:0]   enc_nsyms,
    output logic                    enc_bool_1,
    output logic                    enc_bool_2,
    output logic                    pipe_en,
    output logic                    enc_reset,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy
);

    seq_state_e state_r, state_nxt_s;

    logic                    park_bit_r;
    logic [RANGE_WIDTH-1:0]  park_fl_r, park_fh_r;
    logic [SYMBOL_WIDTH:0]   park_nsyms_r;

    logic [RANGE_WIDTH-1:0]  enc_fl_r, enc_fh_r;
    logic [SYMBOL_WIDTH-1:0] enc_sym1_r, enc_sym2_r;
    logic [SYMBOL_WIDTH:0]   enc_nsyms_r;
    logic                    enc_bool1_r, enc_bool2_r;

    logic [RANGE_WIDTH-1:0]  iss_fl_s, iss_fh_s;
    logic [SYMBOL_WIDTH-1:0] iss_sym1_s, iss_sym2_s;
    logic [SYMBOL_WIDTH:0]   iss_nsyms_s;
    logic                    iss_bool1_s, iss_bool2_s;

    logic [PIPE_DEPTH-1:0]   vld_s;
    logic                    pending_s, adv_s, pair_ok_s;
    logic                    in_ready_s, issue_s, issue_last_s, park_s, drain_s, pipe_en_s;
    logic [SYMBOL_WIDTH-1:0] in_bit_ext_s, park_bit_ext_s;

    assign adv_s          = !pending_s || out_ready;
    assign pair_ok_s      = in_bool && (in_fl == park_fl_r);
    assign in_bit_ext_s   = {{(SYMBOL_WIDTH-1){1'b0}}, in_symbol[0]};
    assign park_bit_ext_s = {{(SYMBOL_WIDTH-1){1'b0}}, park_bit_r};

    // Next-state, handshake and issue-content selection.
    always_comb begin
        state_nxt_s  = state_r;
        in_ready_s   = 1'b0;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        park_s       = 1'b0;
        drain_s      = 1'b0;
        iss_fl_s     = in_fl;
        iss_fh_s     = in_fh;
        iss_sym1_s   = in_symbol;
        iss_sym2_s   = {SYMBOL_WIDTH{1'b0}};
        iss_nsyms_s  = in_nsyms;
        iss_bool1_s  = 1'b0;
        iss_bool2_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = adv_s;
                if (in_valid && adv_s) begin
                    if (in_bool && !in_last) begin
                        park_s      = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        issue_s      = 1'b1;
                        issue_last_s = in_last;
                        iss_bool1_s  = in_bool;
                        iss_sym1_s   = in_bool ? in_bit_ext_s : in_symbol;
                        state_nxt_s  = in_last ? ST_DRAIN : ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Only a pairable symbol is accepted; anything else flushes the
                // parked bool alone and is taken on the following cycle.
                in_ready_s = adv_s && pair_ok_s;
                if (in_valid && adv_s) begin
                    issue_s     = 1'b1;
                    iss_fl_s    = park_fl_r;
                    iss_fh_s    = park_fh_r;
                    iss_nsyms_s = park_nsyms_r;
                    iss_sym1_s  = park_bit_ext_s;
                    iss_bool1_s = 1'b1;
                    if (pair_ok_s) begin
                        iss_bool2_s  = 1'b1;
                        iss_sym2_s   = in_bit_ext_s;
                        issue_last_s = in_last;
                        state_nxt_s  = in_last ? ST_DRAIN : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                // Pulse only while real symbols remain so no bubble reaches the
                // final registers ahead of the re-initialisation.
                if (|vld_s) begin
                    drain_s     = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FRAME_END;
                end
            end
            ST_FRAME_END: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign pipe_en_s = !reset && adv_s && (issue_s || drain_s);

    // State, parked bool and issue registers.
    always_ff @(posedge general_clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            park_bit_r   <= 1'b0;
            park_fl_r    <= {RANGE_WIDTH{1'b0}};
            park_fh_r    <= {RANGE_WIDTH{1'b0}};
            park_nsyms_r <= {(SYMBOL_WIDTH+1){1'b0}};
            enc_fl_r     <= {RANGE_WIDTH{1'b0}};
            enc_fh_r     <= {RANGE_WIDTH{1'b0}};
            enc_sym1_r   <= {SYMBOL_WIDTH{1'b0}};
            enc_sym2_r   <= {SYMBOL_WIDTH{1'b0}};
            enc_nsyms_r  <= {(SYMBOL_WIDTH+1){1'b0}};
            enc_bool1_r  <= 1'b0;
            enc_bool2_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (park_s) begin
                park_bit_r   <= in_symbol[0];
                park_fl_r    <= in_fl;
                park_fh_r    <= in_fh;
                park_nsyms_r <= in_nsyms;
            end else begin
                park_bit_r   <= park_bit_r;
                park_fl_r    <= park_fl_r;
                park_fh_r    <= park_fh_r;
                park_nsyms_r <= park_nsyms_r;
            end
            if (issue_s) begin
                enc_fl_r    <= iss_fl_s;
                enc_fh_r    <= iss_fh_s;
                enc_sym1_r  <= iss_sym1_s;
                enc_sym2_r  <= iss_sym2_s;
                enc_nsyms_r <= iss_nsyms_s;
                enc_bool1_r <= iss_bool1_s;
                enc_bool2_r <= iss_bool2_s;
            end else begin
                enc_fl_r    <= enc_fl_r;
                enc_fh_r    <= enc_fh_r;
                enc_sym1_r  <= enc_sym1_r;
                enc_sym2_r  <= enc_sym2_r;
                enc_nsyms_r <= enc_nsyms_r;
                enc_bool1_r <= enc_bool1_r;
                enc_bool2_r <= enc_bool2_r;
            end
        end
    end

    arith_enc_sequencer_enc_valid_chain #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_valid_chain (
        .general_clk (general_clk),
        .reset       (reset),
        .pipe_en     (pipe_en_s),
        .issue_vld   (issue_s),
        .issue_last  (issue_last_s),
        .out_ready   (out_ready),
        .vld         (vld_s),
        .out_pending (pending_s),
        .out_last    (out_last)
    );

    assign in_ready     = !reset && in_ready_s;
    assign pipe_en      = pipe_en_s;
    assign enc_reset    = reset || (state_r == ST_FRAME_END);
    assign out_valid    = pending_s;
    assign busy         = !reset && ((state_r != ST_IDLE) || (|vld_s) || pending_s);
    assign enc_fl       = enc_fl_r;
    assign enc_fh       = enc_fh_r;
    assign enc_symbol_1 = enc_sym1_r;
    assign enc_symbol_2 = enc_sym2_r;
    assign enc_nsyms    = enc_nsyms_r;
    assign enc_bool_1   = enc_bool1_r;
    assign enc_bool_2   = enc_bool2_r;

endmodule
